imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/arm7_pkg.sv | 22 ++
 rtl/resp_fifo.sv | 82 ++++++++
 rtl/imem_responder.sv | 110 +++++++++++
 tb/tb_imem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7_pkg.sv
// Shared ARM7 core types: machine word, instruction memory depth and the
// response record carried by the fetch path.
package arm7_pkg;

    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 256;

    typedef logic [DATA_W-1:0] word_t;

    // One buffered fetch response: the error flag plus the instruction word.
    typedef struct packed {
        logic  err;
        word_t data;
    } rsp_t;

    // A byte address is unusable if it is not word aligned or its word index
    // lies beyond the end of the instruction memory.
    function automatic logic imem_addr_bad(input word_t addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small circular response buffer with flush and an occupancy count.
// A flush empties the buffer and voids any pop or push in the same cycle.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = slot_q[rd_ptr_q];

    // A push into a full buffer is allowed only when the head leaves that cycle.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Next pointer/count values; pointers wrap at DEPTH so any depth works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state: pointers and count, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; never reset, only read while the entry is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory fetch responder: accepts word fetches, reads a
// synchronous memory into stage S1, then buffers responses in order until
// the consumer takes them. Flush drops everything in flight (branch redirect).
module imem_responder
    import arm7_pkg::*;
#(
    parameter int DEPTH_WORDS = IMEM_DEPTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    word_t            mem [DEPTH_WORDS];
    word_t            rd_q;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q, s1_err_d;
    logic             req_bad;
    logic             load_bad;
    logic             accept;
    logic             fifo_push;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;
    rsp_t             push_rsp;
    rsp_t             head_rsp;

    assign req_bad  = imem_addr_bad(req_addr, DEPTH_WORDS);
    assign load_bad = imem_addr_bad(load_addr, DEPTH_WORDS);
    assign req_idx  = req_addr[IDX_W+1:2];
    assign load_idx = load_addr[IDX_W+1:2];

    // S1 always drains into the buffer next cycle, so S1 plus buffer count is
    // the number of responses owed. Ready uses only registered state and
    // load_en, keeping rsp_ready/flush off the request handshake path.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid_q);
    assign req_ready = !load_en && (occupancy < OCC_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // Program loads write the array; accepted in-range fetches read it at the
    // accept edge. Loads block acceptance, so the two never collide.
    always_ff @(posedge clk) begin
        if (load_en && !load_bad) begin
            mem[load_idx] <= load_data;
        end
        if (accept && !req_bad) begin
            rd_q <= mem[req_idx];
        end
    end

    // S1 holds exactly the request accepted on the previous edge; a flush
    // clears older entries but a same-cycle accept still lands here.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = accept ? req_bad : s1_err_q;
    end

    // S1 control flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
        end
    end

    assign push_rsp.err  = s1_err_q;
    assign push_rsp.data = s1_err_q ? '0 : rd_q;
    assign fifo_push     = s1_valid_q && !flush;

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (push_rsp),
        .pop       (rsp_ready),
        .head_data (head_rsp),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read zero whenever nothing is buffered, including during reset.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0   : head_rsp.data;
    assign rsp_err   = fifo_empty ? 1'b0 : head_rsp.err;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of owed responses.
module tb_imem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int FIFO_DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    // Reference model: memory image and the ordered list of responses owed,
    // each tagged with the first cycle it may be presented.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned rdy;
    } ent_t;

    logic [31:0] mmem [DEPTH_WORDS];
    ent_t        q [$];
    int unsigned cyc = 0;
    bit          last_acc;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH_WORDS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: called just after a falling edge with inputs already set.
    task automatic cycle();
        bit   exp_rdy;
        bit   exp_vld;
        bit   pop;
        ent_t e;
        #1;
        exp_rdy = !load_en && (q.size() < FIFO_DEPTH);
        exp_vld = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        if (exp_vld) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
        last_acc = req_valid && exp_rdy;
        pop      = rsp_ready && exp_vld;
        @(posedge clk);
        cyc++;
        if (flush) q.delete();
        else if (pop) void'(q.pop_front());
        if (last_acc) begin
            e.err  = !addr_ok(req_addr);
            e.data = e.err ? 32'h0 : mmem[req_addr / 4];
            e.rdy  = cyc + 1;
            q.push_back(e);
        end
        if (load_en && addr_ok(load_addr)) mmem[load_addr / 4] = load_data;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold a request until accepted, within a cycle budget.
    task automatic offer(input logic [31:0] a, input int budget);
        bit done = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = last_acc;
        end
        req_valid = 1'b0;
        chk("offer_accepted", 32'(done), 32'd1);
    endtask

    // Raise reset between edges and check the outputs clear without a clock.
    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;

        async_reset_check();
        idle(1);

        // Program load: first two words fixed, the rest random, plus two
        // illegal writes that must not disturb anything.
        load_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_addr = 32'(4 * i);
            load_data = (i == 0) ? 32'hE3A00001 : (i == 1) ? 32'hE2800002 : $urandom;
            cycle();
        end
        load_addr = 32'h6;   load_data = 32'hDEADBEEF; cycle();
        load_addr = 32'h400; load_data = 32'hDEADBEEF; cycle();
        load_en = 1'b0;
        idle(1);

        // Back-to-back fetches of words 0 and 1 with a ready consumer.
        rsp_ready = 1'b1;
        offer(32'h0, 1);
        offer(32'h4, 1);
        idle(4);

        // Consumer stalled: two accepted, third waits until space frees.
        rsp_ready = 1'b0;
        offer(32'h0, 1);
        offer(32'h4, 1);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        idle(3);
        rsp_ready = 1'b1;
        offer(32'h8, 10);
        idle(4);

        // Misaligned and out-of-range fetches.
        offer(32'h2, 3);
        offer(32'h400, 3);
        idle(4);

        // Flush with a full buffer; the waiting request follows.
        rsp_ready = 1'b0;
        offer(32'h0, 1);
        offer(32'h4, 1);
        idle(2);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        cycle();
        flush = 1'b0;
        offer(32'h8, 5);
        rsp_ready = 1'b1;
        idle(4);

        // Flush with room: the request accepted in the flush cycle survives.
        rsp_ready = 1'b0;
        offer(32'h4, 1);
        idle(1);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        cycle();
        chk("flush_cycle_accept", 32'(last_acc), 32'd1);
        flush = 1'b0; req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(4);

        // Load held with a pending request: no accept until load ends.
        load_en = 1'b1; load_addr = 32'h20; load_data = 32'hCAFEF00D;
        req_valid = 1'b1; req_addr = 32'h20;
        idle(3);
        load_en = 1'b0;
        offer(32'h20, 3);
        idle(4);

        // Reset with a full buffer, then a fresh fetch.
        rsp_ready = 1'b0;
        offer(32'h0, 1);
        offer(32'h4, 1);
        idle(2);
        async_reset_check();
        rsp_ready = 1'b1;
        offer(32'h4, 3);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      req_addr = $urandom | 32'h8000_0000;
            else if (r == 1) req_addr = 32'(4 * $urandom_range(0, 15) + 1);
            else             req_addr = 32'(4 * $urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            load_en   = ($urandom_range(0, 24) == 0);
            load_addr = 32'(4 * $urandom_range(0, 15));
            load_data = $urandom;
            cycle();
        end
        req_valid = 1'b0; flush = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
